// File: rtl/snitch_dresp_reorder.sv
// In-order response reorder buffer for the Snitch core data port.
// Each outgoing request is tagged with a slot ID. Responses may come back in
// any order and are parked in their slot. They are handed to the core strictly
// in request order.
module snitch_dresp_reorder #(
    parameter int unsigned NumIds    = 8,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = (NumIds > 1) ? $clog2(NumIds) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // request path: core -> interconnect
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [IdWidth-1:0]   req_id_o,
    // response path: interconnect -> buffer (always accepted)
    input  logic                 resp_valid_i,
    input  logic [IdWidth-1:0]   resp_id_i,
    input  logic [DataWidth-1:0] resp_data_i,
    input  logic                 resp_error_i,
    // in-order response path: buffer -> core
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [DataWidth-1:0] resp_data_o,
    output logic                 resp_error_o
);

    localparam int unsigned CntWidth = $clog2(NumIds + 1);
    localparam logic [IdWidth-1:0]  LastId  = IdWidth'(NumIds - 1);
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(NumIds);

    logic [IdWidth-1:0]   head_q, head_d;
    logic [IdWidth-1:0]   tail_q, tail_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [NumIds-1:0]    alloc_q, alloc_d;
    logic [NumIds-1:0]    filled_q, filled_d;
    logic [NumIds-1:0]    error_q, error_d;
    logic [DataWidth-1:0] data_q [NumIds];
    logic [DataWidth-1:0] data_d [NumIds];

    logic full;
    logic do_alloc;
    logic do_release;

    // Wrap-around increment; NumIds does not have to be a power of two.
    function automatic logic [IdWidth-1:0] next_ptr(input logic [IdWidth-1:0] p);
        return (p == LastId) ? '0 : p + 1'b1;
    endfunction

    // Full depends on the registered count only, so a slot freed this cycle
    // becomes usable next cycle and resp_ready_i never reaches req_ready_o.
    assign full        = (cnt_q == FullCnt);
    assign req_valid_o = req_valid_i & ~full;
    assign req_ready_o = req_ready_i & ~full;
    assign req_id_o    = tail_q;

    // Output straight from the head slot registers: no path from resp_*_i.
    assign resp_valid_o = filled_q[head_q];
    assign resp_data_o  = data_q[head_q];
    assign resp_error_o = error_q[head_q];

    assign do_alloc   = req_valid_o & req_ready_i;
    assign do_release = resp_valid_o & resp_ready_i;

    // Next-state for pointers, count and the per-slot bookkeeping.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        alloc_d  = alloc_q;
        filled_d = filled_q;
        error_d  = error_q;
        data_d   = data_q;

        if (do_release) head_d = next_ptr(head_q);
        if (do_alloc)   tail_d = next_ptr(tail_q);

        unique case ({do_alloc, do_release})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        for (int i = 0; i < int'(NumIds); i++) begin
            if (do_release && (head_q == IdWidth'(i))) begin
                alloc_d[i]  = 1'b0;
                filled_d[i] = 1'b0;
            end
            if (do_alloc && (tail_q == IdWidth'(i))) begin
                alloc_d[i]  = 1'b1;
                filled_d[i] = 1'b0;
            end
            // Responses to free or already-filled slots (e.g. stale IDs from
            // before a reset) are dropped without touching any state.
            if (resp_valid_i && (resp_id_i == IdWidth'(i)) && alloc_q[i] && !filled_q[i]) begin
                filled_d[i] = 1'b1;
                data_d[i]   = resp_data_i;
                error_d[i]  = resp_error_i;
            end
        end
    end

    // State registers, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            alloc_q  <= '0;
            filled_q <= '0;
            error_q  <= '0;
            for (int i = 0; i < int'(NumIds); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            alloc_q  <= alloc_d;
            filled_q <= filled_d;
            error_q  <= error_d;
            data_q   <= data_d;
        end
    end

`ifndef SYNTHESIS
    // A response must target an allocated, not-yet-filled slot.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        resp_valid_i |-> ((32'(resp_id_i) < NumIds) && alloc_q[resp_id_i] && !filled_q[resp_id_i]))
    else $warning("snitch_dresp_reorder: protocol error, response id %0d to free or filled slot", resp_id_i);
`endif

endmodule

// File: tb/tb_snitch_dresp_reorder.sv
// Directed bench for snitch_dresp_reorder: an 8-slot instance for the main
// scenarios and a 5-slot instance for non-power-of-two pointer wrap.
module tb_snitch_dresp_reorder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // 8-slot instance signals
    logic        req_valid_i, req_ready_i, resp_valid_i, resp_error_i, resp_ready_i;
    logic [2:0]  resp_id_i;
    logic [31:0] resp_data_i;
    logic        req_ready_o, req_valid_o, resp_valid_o, resp_error_o;
    logic [2:0]  req_id_o;
    logic [31:0] resp_data_o;

    // 5-slot instance signals
    logic        f_req_valid_i, f_req_ready_i, f_resp_valid_i, f_resp_error_i, f_resp_ready_i;
    logic [2:0]  f_resp_id_i;
    logic [31:0] f_resp_data_i;
    logic        f_req_ready_o, f_req_valid_o, f_resp_valid_o, f_resp_error_o;
    logic [2:0]  f_req_id_o;
    logic [31:0] f_resp_data_o;

    snitch_dresp_reorder #(.NumIds(8), .DataWidth(32)) dut8 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_id_o(req_id_o),
        .resp_valid_i(resp_valid_i), .resp_id_i(resp_id_i),
        .resp_data_i(resp_data_i), .resp_error_i(resp_error_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_error_o(resp_error_o)
    );

    snitch_dresp_reorder #(.NumIds(5), .DataWidth(32)) dut5 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(f_req_valid_i), .req_ready_o(f_req_ready_o),
        .req_valid_o(f_req_valid_o), .req_ready_i(f_req_ready_i), .req_id_o(f_req_id_o),
        .resp_valid_i(f_resp_valid_i), .resp_id_i(f_resp_id_i),
        .resp_data_i(f_resp_data_i), .resp_error_i(f_resp_error_i),
        .resp_valid_o(f_resp_valid_o), .resp_ready_i(f_resp_ready_i),
        .resp_data_o(f_resp_data_o), .resp_error_o(f_resp_error_o)
    );

    task automatic idle_inputs();
        req_valid_i = 0; req_ready_i = 0; resp_valid_i = 0; resp_error_i = 0;
        resp_ready_i = 0; resp_id_i = '0; resp_data_i = '0;
        f_req_valid_i = 0; f_req_ready_i = 0; f_resp_valid_i = 0; f_resp_error_i = 0;
        f_resp_ready_i = 0; f_resp_id_i = '0; f_resp_data_i = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", req_valid_o); end
        n_cmp++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready_o); end
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid_o); end
        n_cmp++; if (req_id_o !== 3'd0) begin n_fail++; $display("FAIL reset_req_id: got %0d want 0", req_id_o); end
        n_cmp++; if (resp_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", resp_data_o); end
        n_cmp++; if (resp_error_o !== 1'b0) begin n_fail++; $display("FAIL reset_resp_error: got %b want 0", resp_error_o); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset: outputs checked during reset");
    endtask

    task automatic test_single_load();
        apply_reset();
        req_valid_i = 1; req_ready_i = 1; #1;
        n_cmp++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_req_valid: got %b want 1", req_valid_o); end
        n_cmp++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_req_ready: got %b want 1", req_ready_o); end
        n_cmp++; if (req_id_o !== 3'd0) begin n_fail++; $display("FAIL single_req_id: got %0d want 0", req_id_o); end
        @(negedge clk);
        req_valid_i = 0; req_ready_i = 0;
        resp_valid_i = 1; resp_id_i = 3'd0; resp_data_i = 32'hDEAD_BEEF; #1;
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_no_comb_path: got %b want 0", resp_valid_o); end
        @(negedge clk);
        resp_valid_i = 0; resp_data_i = '0; #1;
        n_cmp++; if (resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_resp_valid: got %b want 1", resp_valid_o); end
        n_cmp++; if (resp_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_resp_data: got %h want deadbeef", resp_data_o); end
        resp_ready_i = 1;
        @(negedge clk);
        resp_ready_i = 0; #1;
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_released: got %b want 0", resp_valid_o); end
        n_cmp++; if (dut8.cnt_q !== 4'd0) begin n_fail++; $display("FAIL single_cnt: got %0d want 0", dut8.cnt_q); end
        $display("txn single_load: id 0 data deadbeef");
    endtask

    task automatic test_reorder();
        logic [2:0]  ids [3];
        logic [31:0] rdat [3];
        logic        rerr [3];
        logic [31:0] exp_dat [3];
        logic        exp_err [3];
        ids = '{3'd2, 3'd0, 3'd1};
        rdat = '{32'hC, 32'hA, 32'hB};
        rerr = '{1'b0, 1'b0, 1'b1};
        exp_dat = '{32'hA, 32'hB, 32'hC};
        exp_err = '{1'b0, 1'b1, 1'b0};
        apply_reset();
        req_valid_i = 1; req_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (req_id_o !== 3'(i)) begin n_fail++; $display("FAIL reorder_req_id: got %0d want %0d", req_id_o, i); end
            @(negedge clk);
        end
        req_valid_i = 0; req_ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            resp_valid_i = 1; resp_id_i = ids[k]; resp_data_i = rdat[k]; resp_error_i = rerr[k];
            @(negedge clk);
            if (k == 0) begin
                #1;
                n_cmp++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reorder_head_wait: got %b want 0", resp_valid_o); end
            end
        end
        resp_valid_i = 0; resp_error_i = 0; resp_ready_i = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL reorder_valid%0d: got %b want 1", k, resp_valid_o); end
            n_cmp++; if (resp_data_o !== exp_dat[k]) begin n_fail++; $display("FAIL reorder_data%0d: got %h want %h", k, resp_data_o, exp_dat[k]); end
            n_cmp++; if (resp_error_o !== exp_err[k]) begin n_fail++; $display("FAIL reorder_error%0d: got %b want %b", k, resp_error_o, exp_err[k]); end
            @(negedge clk);
        end
        resp_ready_i = 0; #1;
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reorder_drained: got %b want 0", resp_valid_o); end
        $display("txn reorder: responses 2,0,1 delivered as a,b,c");
    endtask

    task automatic test_full();
        apply_reset();
        req_valid_i = 1; req_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++; if (req_id_o !== 3'(i)) begin n_fail++; $display("FAIL full_req_id: got %0d want %0d", req_id_o, i); end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_req_ready: got %b want 0", req_ready_o); end
        n_cmp++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_req_valid: got %b want 0", req_valid_o); end
        resp_valid_i = 1; resp_id_i = 3'd0; resp_data_i = 32'h100;
        @(negedge clk);
        resp_valid_i = 0; resp_ready_i = 1; #1;
        n_cmp++; if (resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_head_valid: got %b want 1", resp_valid_o); end
        n_cmp++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_no_fallthrough: got %b want 0", req_valid_o); end
        @(negedge clk);
        resp_ready_i = 0; #1;
        n_cmp++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_resume_valid: got %b want 1", req_valid_o); end
        n_cmp++; if (req_id_o !== 3'd0) begin n_fail++; $display("FAIL full_wrap_id: got %0d want 0", req_id_o); end
        @(negedge clk);
        #1;
        n_cmp++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_refilled: got %b want 0", req_ready_o); end
        req_valid_i = 0; req_ready_i = 0;
        $display("txn full: 8 outstanding, slot 0 reused after release");
    endtask

    task automatic test_backpressure();
        apply_reset();
        req_valid_i = 1; req_ready_i = 1;
        @(negedge clk);
        req_valid_i = 0; req_ready_i = 0;
        resp_valid_i = 1; resp_id_i = 3'd0; resp_data_i = 32'h55AA_1234; resp_error_i = 1;
        @(negedge clk);
        resp_valid_i = 0; resp_error_i = 0; resp_data_i = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d: got %b want 1", c, resp_valid_o); end
            n_cmp++; if (resp_data_o !== 32'h55AA_1234) begin n_fail++; $display("FAIL bp_data_c%0d: got %h want 55aa1234", c, resp_data_o); end
            n_cmp++; if (resp_error_o !== 1'b1) begin n_fail++; $display("FAIL bp_error_c%0d: got %b want 1", c, resp_error_o); end
            @(negedge clk);
        end
        resp_ready_i = 1;
        @(negedge clk);
        resp_ready_i = 0; #1;
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", resp_valid_o); end
        n_cmp++; if (dut8.cnt_q !== 4'd0) begin n_fail++; $display("FAIL bp_cnt: got %0d want 0", dut8.cnt_q); end
        $display("txn backpressure: held 5 cycles then released");
    endtask

    task automatic test_simultaneous();
        apply_reset();
        req_valid_i = 1; req_ready_i = 1;
        repeat (4) @(negedge clk);
        req_valid_i = 0; req_ready_i = 0;
        resp_valid_i = 1; resp_id_i = 3'd0; resp_data_i = 32'h1;
        @(negedge clk);
        resp_valid_i = 0;
        req_valid_i = 1; req_ready_i = 1; resp_ready_i = 1; #1;
        n_cmp++; if (req_id_o !== 3'd4) begin n_fail++; $display("FAIL simul_req_id: got %0d want 4", req_id_o); end
        n_cmp++; if (dut8.cnt_q !== 4'd4) begin n_fail++; $display("FAIL simul_cnt_before: got %0d want 4", dut8.cnt_q); end
        @(negedge clk);
        req_valid_i = 0; req_ready_i = 0; resp_ready_i = 0; #1;
        n_cmp++; if (dut8.cnt_q !== 4'd4) begin n_fail++; $display("FAIL simul_cnt_after: got %0d want 4", dut8.cnt_q); end
        n_cmp++; if (dut8.head_q !== 3'd1) begin n_fail++; $display("FAIL simul_head: got %0d want 1", dut8.head_q); end
        n_cmp++; if (req_id_o !== 3'd5) begin n_fail++; $display("FAIL simul_tail: got %0d want 5", req_id_o); end
        $display("txn simultaneous: alloc+release at cnt 4");
    endtask

    task automatic test_wrap5();
        logic [2:0]  rid [4];
        logic [31:0] exp_dat [4];
        rid = '{3'd0, 3'd4, 3'd3, 3'd2};
        exp_dat = '{32'h62, 32'h63, 32'h64, 32'h60};
        apply_reset();
        f_req_valid_i = 1; f_req_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (f_req_id_o !== 3'(i)) begin n_fail++; $display("FAIL wrap5_req_id: got %0d want %0d", f_req_id_o, i); end
            @(negedge clk);
        end
        f_req_valid_i = 0; f_req_ready_i = 0;
        for (int r = 0; r < 2; r++) begin
            f_resp_valid_i = 1; f_resp_id_i = 3'(r); f_resp_data_i = 32'h50 + 32'(r);
            @(negedge clk);
            f_resp_valid_i = 0;
            f_req_valid_i = 1; f_req_ready_i = 1; f_resp_ready_i = 1; #1;
            n_cmp++; if (f_resp_data_o !== 32'h50 + 32'(r)) begin n_fail++; $display("FAIL wrap5_head_data%0d: got %h want %h", r, f_resp_data_o, 32'h50 + 32'(r)); end
            @(negedge clk);
            f_req_valid_i = 0; f_req_ready_i = 0; f_resp_ready_i = 0; #1;
            n_cmp++; if (f_req_id_o !== 3'(r)) begin n_fail++; $display("FAIL wrap5_tail%0d: got %0d want %0d", r, f_req_id_o, r); end
            n_cmp++; if (dut5.cnt_q !== 3'd4) begin n_fail++; $display("FAIL wrap5_cnt%0d: got %0d want 4", r, dut5.cnt_q); end
        end
        for (int k = 0; k < 4; k++) begin
            f_resp_valid_i = 1; f_resp_id_i = rid[k]; f_resp_data_i = 32'h60 + 32'(rid[k]);
            @(negedge clk);
        end
        f_resp_valid_i = 0; f_resp_ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (f_resp_data_o !== exp_dat[k]) begin n_fail++; $display("FAIL wrap5_order%0d: got %h want %h", k, f_resp_data_o, exp_dat[k]); end
            @(negedge clk);
        end
        f_resp_ready_i = 0; #1;
        n_cmp++; if (dut5.cnt_q !== 3'd0) begin n_fail++; $display("FAIL wrap5_drained: got %0d want 0", dut5.cnt_q); end
        $display("txn wrap5: non-power-of-two wrap with reordered drain");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_valid_i = 1; req_ready_i = 1;
        repeat (3) @(negedge clk);
        idle_inputs();
        rst_n = 1'b0; #1;
        n_cmp++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_valid: got %b want 0", req_valid_o); end
        n_cmp++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_ready: got %b want 0", req_ready_o); end
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp_valid: got %b want 0", resp_valid_o); end
        n_cmp++; if (req_id_o !== 3'd0) begin n_fail++; $display("FAIL rstmid_req_id: got %0d want 0", req_id_o); end
        n_cmp++; if (resp_data_o !== 32'd0) begin n_fail++; $display("FAIL rstmid_resp_data: got %h want 0", resp_data_o); end
        n_cmp++; if (resp_error_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp_error: got %b want 0", resp_error_o); end
        @(negedge clk);
        rst_n = 1'b1;
        resp_valid_i = 1; resp_id_i = 3'd1; resp_data_i = 32'h77;
        @(negedge clk);
        resp_valid_i = 0; resp_data_i = '0; #1;
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_resp: got %b want 0", resp_valid_o); end
        n_cmp++; if (dut8.filled_q !== 8'd0) begin n_fail++; $display("FAIL rstmid_stale_filled: got %b want 0", dut8.filled_q); end
        req_valid_i = 1; req_ready_i = 1; #1;
        n_cmp++; if (req_id_o !== 3'd0) begin n_fail++; $display("FAIL rstmid_next_id: got %0d want 0", req_id_o); end
        @(negedge clk);
        req_valid_i = 0; req_ready_i = 0;
        $display("txn reset_mid: stale response dropped, id restarts at 0");
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_reorder();
        test_full();
        test_backpressure();
        test_simultaneous();
        test_wrap5();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
